// File: rtl/piso_tx_pkg.sv
// Shared definitions for the piso_tx serial frame transmitter.
//
// Contents:
//   state_e      FSM state encoding, 3 bits wide
//   IDLE_LEVEL   level of the serial line when idle and during stop bits
//   START_LEVEL  level of the start bit
//   frame_len()  number of serial cycles in one frame, for the given configuration
package piso_tx_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Start bit + data bits + optional parity bit + stop bits.
    function automatic int unsigned frame_len(input int unsigned width,
                                              input int unsigned parity_en,
                                              input int unsigned stop_bits);
        return 1 + width + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/piso_tx_hold_buf.sv
// piso_hold_buf: one-entry holding register between the parallel producer and the
// transmitter's shifter.
//
// Ports:
//   clk          clock, all updates on the rising edge
//   rst_n        asynchronous active-low reset; empties the buffer and clears the word
//   din_i        parallel word from the producer
//   din_valid_i  producer has a word this cycle
//   din_ready_o  buffer is empty; a transfer happens when din_valid_i & din_ready_o
//   out_word_o   the held word
//   out_full_o   buffer holds a word
//   pop_i        consumer takes the held word on this edge
//
// din_ready_o comes straight from a register, so the producer never sees a
// combinational path from the consumer side. Because a word can only be pushed while the
// buffer is empty and only popped while it is full, push and pop never coincide.
module piso_hold_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    output logic [WIDTH-1:0] out_word_o,
    output logic             out_full_o,
    input  logic             pop_i
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             push;

    assign push = din_valid_i & ~full_q;

    always_comb begin
        full_d = full_q;
        word_d = word_q;
        if (push) begin
            full_d = 1'b1;
            word_d = din_i;
        end else if (pop_i && full_q) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            word_q <= '0;
        end else begin
            full_q <= full_d;
            word_q <= word_d;
        end
    end

    assign din_ready_o = ~full_q;
    assign out_word_o  = word_q;
    assign out_full_o  = full_q;

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out frame transmitter.
//
// Each accepted WIDTH-bit word goes out on so_o as one frame: a start bit (0), the data
// MSB first, an optional even-parity bit, then STOP_BITS stop bits (1). A one-entry holding
// buffer in front of the shifter lets the next word wait while a frame is on the line, so
// consecutive frames run with no idle gap.
//
// Parameters:
//   WIDTH      data bits per frame, 1..32
//   PARITY_EN  1 appends an even-parity bit after the data
//   STOP_BITS  stop-bit cycles, 1 or 2
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset; aborts any frame in progress
//   din_i         parallel word to send
//   din_valid_i   din_i is valid this cycle
//   din_ready_o   holding buffer empty; transfer when din_valid_i & din_ready_o
//   so_o          registered serial output, idle level 1
//   busy_o        a frame bit is on so_o
//   frame_done_o  one-cycle pulse during the last stop bit on so_o
//
// Timing: the FSM state names the bit that is driven onto so_o on the following edge, so
// the serial register (and the busy/frame_done registers that accompany it) trail the state
// register by one cycle. A word accepted at edge N is loaded into the shifter at N+1 and its
// start bit appears on so_o from edge N+2.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PARITY_EN = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    output logic             so_o,
    output logic             busy_o,
    output logic             frame_done_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    // Holding buffer
    logic [WIDTH-1:0] buf_word;
    logic             buf_full;
    logic             buf_pop;

    piso_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_i      (din_i),
        .din_valid_i(din_valid_i),
        .din_ready_o(din_ready_o),
        .out_word_o (buf_word),
        .out_full_o (buf_full),
        .pop_i      (buf_pop)
    );

    // Transmit state
    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic             so_q, so_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             stop_last;

    assign stop_last = (stop_cnt_q == 1'(STOP_BITS - 1));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        buf_pop    = 1'b0;
        so_d       = IDLE_LEVEL;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (buf_full) begin
                    buf_pop = 1'b1;
                    shift_d = buf_word;
                    // Parity comes from the latched word so din_i may change freely.
                    par_d   = ^buf_word;
                    state_d = StStart;
                end
            end

            StStart: begin
                so_d      = START_LEVEL;
                busy_d    = 1'b1;
                bit_cnt_d = CntW'(WIDTH - 1);
                state_d   = StData;
            end

            StData: begin
                so_d    = shift_q[WIDTH-1];
                busy_d  = 1'b1;
                shift_d = shift_q << 1;
                if (bit_cnt_q == '0) begin
                    stop_cnt_d = 1'b0;
                    state_d    = (PARITY_EN != 0) ? StParity : StStop;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end

            StParity: begin
                so_d       = par_q;
                busy_d     = 1'b1;
                stop_cnt_d = 1'b0;
                state_d    = StStop;
            end

            StStop: begin
                so_d   = IDLE_LEVEL;
                busy_d = 1'b1;
                if (stop_last) begin
                    done_d = 1'b1;
                    // A waiting word starts its frame right behind this stop bit.
                    if (buf_full) begin
                        buf_pop = 1'b1;
                        shift_d = buf_word;
                        par_d   = ^buf_word;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            so_q       <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            so_q       <= so_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign so_o         = so_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx. Three instances cover the configurations exercised:
//   d0: WIDTH=8 PARITY_EN=1 STOP_BITS=1
//   d1: WIDTH=8 PARITY_EN=0 STOP_BITS=2
//   d2: WIDTH=1 PARITY_EN=1 STOP_BITS=1
// Stimulus pushes each frame's hand-written bit string into that instance's queue; the
// monitor pops one entry per busy cycle and compares {so, frame_done}.
module tb_piso_tx;
    import piso_tx_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] din0, din1;
    logic [0:0] din2;
    logic [2:0] valid_v;
    wire  [2:0] ready_v, so_v, busy_v, done_v;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    logic [1:0] exp0[$];
    logic [1:0] exp1[$];
    logic [1:0] exp2[$];
    int done_cnt[3];
    int last_done_cyc[3];
    int prev_done_cyc[3];

    always @(posedge clk) cyc <= cyc + 1;

    piso_tx #(.WIDTH(8), .PARITY_EN(1), .STOP_BITS(1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .din_i(din0), .din_valid_i(valid_v[0]),
        .din_ready_o(ready_v[0]), .so_o(so_v[0]), .busy_o(busy_v[0]),
        .frame_done_o(done_v[0])
    );

    piso_tx #(.WIDTH(8), .PARITY_EN(0), .STOP_BITS(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .din_i(din1), .din_valid_i(valid_v[1]),
        .din_ready_o(ready_v[1]), .so_o(so_v[1]), .busy_o(busy_v[1]),
        .frame_done_o(done_v[1])
    );

    piso_tx #(.WIDTH(1), .PARITY_EN(1), .STOP_BITS(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .din_i(din2), .din_valid_i(valid_v[2]),
        .din_ready_o(ready_v[2]), .so_o(so_v[2]), .busy_o(busy_v[2]),
        .frame_done_o(done_v[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
    endtask

    task automatic push_frame(input int d, input string bits);
        for (int i = 0; i < bits.len(); i++) begin
            logic [1:0] e;
            e[1] = (bits[i] == "1");
            e[0] = (i == bits.len() - 1);
            case (d)
                0:       exp0.push_back(e);
                1:       exp1.push_back(e);
                default: exp2.push_back(e);
            endcase
        end
    endtask

    task automatic set_din(input int d, input logic [7:0] w);
        case (d)
            0:       din0 = w;
            1:       din1 = w;
            default: din2 = w[0];
        endcase
    endtask

    // Presents w and waits for the handshake; returns with din_valid still high, 1 time unit
    // after the accepting edge. edges = number of rising edges waited.
    task automatic send(input int d, input logic [7:0] w, input string bits, output int edges);
        bit done;
        done  = 1'b0;
        edges = 0;
        set_din(d, w);
        valid_v[d] = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            logic r;
            @(negedge clk);
            r = ready_v[d];
            @(posedge clk);
            edges++;
            if (r) begin
                push_frame(d, bits);
                done = 1'b1;
            end
        end
        #1;
        if (!done) fail_now($sformatf("accept_timeout_d%0d", d));
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(posedge clk);
            #1;
            idle = (exp0.size() == 0) && (exp1.size() == 0) && (exp2.size() == 0) &&
                   (busy_v == 3'b000);
        end
        if (!idle) fail_now("drain_timeout");
    endtask

    // Monitor
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                logic [1:0] e;
                bit have;
                have = 1'b0;
                e    = 2'b00;
                if (busy_v[d]) begin
                    case (d)
                        0: if (exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
                        1: if (exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
                        default:
                           if (exp2.size() > 0) begin e = exp2.pop_front(); have = 1'b1; end
                    endcase
                    if (!have) fail_now($sformatf("unexpected_bit_d%0d", d));
                    else check($sformatf("frame_bit_d%0d_so_done", d),
                               {30'd0, so_v[d], done_v[d]}, {30'd0, e});
                    if (done_v[d]) begin
                        done_cnt[d]++;
                        prev_done_cyc[d] = last_done_cyc[d];
                        last_done_cyc[d] = cyc;
                    end
                end else begin
                    check($sformatf("idle_d%0d_so_done", d), {30'd0, so_v[d], done_v[d]},
                          32'h2);
                end
            end
        end
    end

    initial begin
        int e;
        int acc;
        for (int i = 0; i < 3; i++) begin
            done_cnt[i]      = 0;
            last_done_cyc[i] = 0;
            prev_done_cyc[i] = 0;
        end
        valid_v = 3'b000;
        din0    = 8'h00;
        din1    = 8'h00;
        din2    = 1'b0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;

        // 1. Reset held with din_valid high
        din0       = 8'hA5;
        valid_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_so", so_v[0], 1);
        check("rst_busy", busy_v[0], 0);
        check("rst_ready", ready_v[0], 1);
        check("rst_done", done_v[0], 0);
        mon_en = 1'b1;
        #1 rst_n = 1'b1;

        // 2. First accept on the next edge: 0xA5 with parity
        @(posedge clk);
        push_frame(0, "01010010101");
        #1;
        valid_v[0] = 1'b0;
        check("accept_first_edge_ready_low", ready_v[0], 0);
        @(posedge clk);
        #1;
        check("lat_n1_so", so_v[0], 1);
        check("lat_n1_busy", busy_v[0], 0);
        @(posedge clk);
        #1;
        check("lat_n2_so_start", so_v[0], 0);
        check("lat_n2_busy", busy_v[0], 1);
        drain();
        check("a5_after_so", so_v[0], 1);
        check("a5_after_busy", busy_v[0], 0);

        // 3. Back-to-back 0x00, 0xFF with din_valid held high
        send(1, 8'h00, "00000000011", e);
        check("b2b_ready_low_after_accept", ready_v[1], 0);
        send(1, 8'hFF, "01111111111", e);
        check("b2b_second_accept_edges", e, 2);
        valid_v[1] = 1'b0;
        drain();
        check("b2b_no_gap_d1", last_done_cyc[1] - prev_done_cyc[1], frame_len(8, 0, 2));

        // 4. Backpressure: 0x3C waits in the buffer, din churns while stalled
        send(0, 8'h12, "00001001001", e);
        send(0, 8'h3C, "00011110001", e);
        for (int i = 0; i < 5; i++) begin
            din0 = 8'h55 + 8'(i * 37);
            @(negedge clk);
            check($sformatf("stall_ready_low_%0d", i), ready_v[0], 0);
            @(posedge clk);
            #1;
        end
        valid_v[0] = 1'b0;
        drain();
        check("bp_no_gap_d0", last_done_cyc[0] - prev_done_cyc[0], frame_len(8, 1, 1));

        // 5. Reset mid-frame during 0x81
        send(0, 8'h81, "01000000101", e);
        valid_v[0] = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        check("abort_pre_so", so_v[0], 0);
        rst_n = 1'b0;
        #1;
        check("abort_so", so_v[0], 1);
        check("abort_busy", busy_v[0], 0);
        check("abort_done", done_v[0], 0);
        check("abort_ready", ready_v[0], 1);
        exp0.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("abort_idle_busy", busy_v[0], 0);
        check("abort_idle_so", so_v[0], 1);

        // 6. WIDTH=1 with parity, send 1
        send(2, 8'h01, "0111", e);
        acc = cyc;
        valid_v[2] = 1'b0;
        drain();
        check("w1_done_latency", last_done_cyc[2] - acc, 1 + frame_len(1, 1, 1));

        check("done_cnt_d0", done_cnt[0], 3);
        check("done_cnt_d1", done_cnt[1], 2);
        check("done_cnt_d2", done_cnt[2], 1);
        check("queues_empty", exp0.size() + exp1.size() + exp2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
